// File: rtl/drac_pkg.sv
// Shared types and constants for the DRAC integer pipeline.
// Holds the decode->rr, rr->exe and write-back bundle types, the register
// index and 64-bit bus types, and the functional-unit encoding.
package drac_pkg;

  localparam int NUM_REGS_C = 32;
  localparam int XLEN_C     = 64;

  typedef logic [63:0] bus64_t;
  typedef logic [4:0]  reg_t;

  // UNIT_ALU is encoded as zero, so a cleared pipeline register already
  // reads as an ALU bubble.
  typedef enum logic [2:0] {
    UNIT_ALU     = 3'd0,
    UNIT_DIV     = 3'd1,
    UNIT_MUL     = 3'd2,
    UNIT_BRANCH  = 3'd3,
    UNIT_MEM     = 3'd4,
    UNIT_CONTROL = 3'd5
  } unit_t;

  typedef struct packed {
    logic   valid;
    bus64_t pc;
    reg_t   rs1;
    reg_t   rs2;
    reg_t   rd;
    logic   regfile_we;
    unit_t  unit;
  } instr_t;

  typedef struct packed {
    logic   valid;
    instr_t instr;
  } id_rr_instr_t;

  typedef struct packed {
    instr_t instr;
    bus64_t data_rs1;
    bus64_t data_rs2;
  } rr_exe_instr_t;

  typedef struct packed {
    logic   valid;
    reg_t   rd;
    bus64_t data;
  } wb_exe_instr_t;

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one write port.
// x0 reads as zero and ignores writes. A read of the register being written
// in the same cycle returns the incoming write data (write-through).
// Ports:
//   clk, srst            clock, synchronous active-high clear of all registers
//   we, waddr, wdata     write port
//   raddr1/2, rdata1/2   read ports (combinational)
module regfile
  import drac_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic   clk,
  input  logic   srst,
  input  logic   we,
  input  reg_t   waddr,
  input  bus64_t wdata,
  input  reg_t   raddr1,
  input  reg_t   raddr2,
  output bus64_t rdata1,
  output bus64_t rdata2
);

  bus64_t regs [NUM_REGS];
  reg_t   raddr [2];
  bus64_t rdata [2];
  logic   wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      // wr_en already excludes x0, so the zero check only guards the array read.
      assign rdata[gi] = (raddr[gi] == '0)                ? '0    :
                         (wr_en && (waddr == raddr[gi]))  ? wdata :
                                                            regs[raddr[gi]];
    end
  endgenerate

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

endmodule

// File: rtl/rr_stage.sv
// Register-read stage: reads both operands from the register file, with
// write-through from write-back, and registers instruction plus operands
// into the rr->exe pipeline register. While stalled the held operands are
// refreshed from write-back; kill turns the held entry into an ALU bubble.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   kill_i               pipeline flush
//   stall_i              stall from the execution stage
//   from_id_i            decoded instruction
//   from_wb_i            register file write port
//   to_exe_o             registered instruction and operands
//   stall_o              backpressure to decode
module rr_stage
  import drac_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          kill_i,
  input  logic          stall_i,
  input  id_rr_instr_t  from_id_i,
  input  wb_exe_instr_t from_wb_i,
  output rr_exe_instr_t to_exe_o,
  output logic          stall_o
);

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  rr_exe_instr_t   exe_reg;
  rr_exe_instr_t   exe_next;
  logic            refresh_rs1;
  logic            refresh_rs2;

  regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk    (clk_i),
    .srst   (rst_i),
    .we     (from_wb_i.valid),
    .waddr  (from_wb_i.rd),
    .wdata  (from_wb_i.data),
    .raddr1 (from_id_i.instr.rs1),
    .raddr2 (from_id_i.instr.rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // A held instruction may be waiting on a producer that writes back while
  // we stall; pick the value up directly into the pipeline register.
  assign refresh_rs1 = from_wb_i.valid && (from_wb_i.rd != '0) &&
                       (from_wb_i.rd == exe_reg.instr.rs1);
  assign refresh_rs2 = from_wb_i.valid && (from_wb_i.rd != '0) &&
                       (from_wb_i.rd == exe_reg.instr.rs2);

  always_comb begin
    exe_next = exe_reg;
    if (kill_i) begin
      exe_next.instr.valid = 1'b0;
      exe_next.instr.unit  = UNIT_ALU;
    end else if (stall_i) begin
      if (refresh_rs1) exe_next.data_rs1 = from_wb_i.data;
      if (refresh_rs2) exe_next.data_rs2 = from_wb_i.data;
    end else begin
      exe_next.instr       = from_id_i.instr;
      exe_next.instr.valid = from_id_i.valid;
      exe_next.data_rs1    = rs1_data;
      exe_next.data_rs2    = rs2_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exe_reg <= '0;
    end else begin
      exe_reg <= exe_next;
    end
  end

  assign to_exe_o = exe_reg;
  assign stall_o  = stall_i & ~kill_i;

endmodule

// File: doc/rr_stage.md
# rr_stage

Register-read stage of the DRAC integer pipeline: sits between decode and `exe_top`. Holds the 32×64-bit integer register file, reads both source operands with same-cycle write-through from write-back, and registers the instruction plus operands into the rr→exe pipeline register consumed by the execution stage. It also propagates execution-stage stalls upstream and squashes on kill.

## Interface
Parameters:
- `NUM_REGS`, 32: architectural integer registers; x0 is hardwired to zero.
- `XLEN`, 64: register width; must equal the width of `bus64_t`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `kill_i`  in  1  pipeline flush from branch or exception resolution.
- `stall_i`  in  1  `stall_o` of the execution stage.
- `from_id_i`  in  `id_rr_instr_t`  decoded instruction: `valid`, `instr` with `rs1`, `rs2`, `rd`, `regfile_we`, `unit`.
- `from_wb_i`  in  `wb_exe_instr_t`  write port: `valid`, `rd`, `data`.
- `to_exe_o`  out  `rr_exe_instr_t`  registered `instr`, `data_rs1`, `data_rs2`.
- `stall_o`  out  1  backpressure to decode.

## Operation
- Register file write: on an edge with `from_wb_i.valid` and `rd != 0`, `regs[rd] <= data`. Writes to x0 are dropped.
- Operand read is combinational from `regs` during the rr cycle.
- Write-through: if `from_wb_i.valid`, `rd != 0` and `rd == rsN`, operand N takes `from_wb_i.data` instead of the array value.
- `rsN == 0` always yields 0, regardless of any write-back.
- Pipeline register update on each edge, in priority order:
  - `rst_i`: all fields of `to_exe_o` are 0, including `instr.valid` and `unit`. All `regs` are cleared to 0.
  - `kill_i`: `to_exe_o.instr.valid <= 0` and `unit <= UNIT_ALU`; the other fields are don't-care. The write-back write on the same edge is still performed, because the writing instruction is older.
  - `stall_i`: the held instruction keeps `instr` unchanged. Operand refresh: if `from_wb_i` writes a register matching the held `rs1`/`rs2` (non-zero), the corresponding `data_rsN` is updated to `from_wb_i.data`.
  - Otherwise: capture `from_id_i.instr` and the resolved operands. If `from_id_i.valid == 0`, a bubble is loaded (`valid = 0`).
- `stall_o = stall_i & ~kill_i`, combinational. When decode sees `stall_o`, it holds `from_id_i` stable; rr re-reads every cycle, so a held instruction picks up any write-back that occurs while it waits.
- No load-use or multi-cycle interlock is needed here: an exe→rr distance of 1 is covered by the exe bypass from wb, and a distance of 2 is covered by write-through.

## Timing
- Latency: 1 cycle from `from_id_i` to `to_exe_o`.
- A register written at edge N is visible in the array read from cycle N+1 onward. In cycle N itself it is visible through write-through.
- `stall_o` has zero-cycle latency from `stall_i`.
- Kill takes effect at the next edge: `to_exe_o.valid` is 0 in the cycle after `kill_i`.
- Reset mid-stall: reset wins. Output is zeroed and the register file is cleared on the same edge.

## Structure
- `drac_pkg` holds the shared types and constants:
  - types `id_rr_instr_t`, `rr_exe_instr_t`, `wb_exe_instr_t`, `reg_t` (5 bits), `bus64_t`;
  - constant `UNIT_ALU`;
  - no new types are added.
- Sub-module `regfile`:
  - 2 combinational read ports and 1 write port, with x0 forced to zero;
  - synchronous active-high clear;
  - the write-through mux lives in `regfile`, so `rr_stage` contains only the pipeline register, the refresh logic and the stall/kill logic.

## Test plan
- Reset then read: assert `rst_i` for 2 cycles, then issue `rs1=5, rs2=0` → `to_exe_o` data 0/0 one cycle later; `valid=0` during reset.
- Write-through: wb writes x7=0xDEAD_BEEF in the same cycle that rr reads `rs1=7` → next cycle `data_rs1=0xDEAD_BEEF`. Then wb writes x0=0x55 while reading `rs2=0` → `data_rs2=0`.
- Stall with refresh: the held instruction has `rs2=9`; hold `stall_i` for 3 cycles; wb writes x9=0x1234 in stall cycle 2 → `data_rs2=0x1234` from the next cycle; `instr` is unchanged; `stall_o` is high for all 3 cycles.
- Kill during stall: `stall_i=1` and `kill_i=1` with wb writing x3=0x42 → next cycle `valid=0`, `stall_o=0`; a later read of x3 returns 0x42.
- Back-to-back: writes x1=1, x2=2, x3=3 on three consecutive wb cycles, while rr reads x1, x2, x3 one cycle behind each write → captured values are 1, 2, 3.
- Bubble: `from_id_i.valid=0` with no stall → `to_exe_o.instr.valid=0` next cycle.
